logicnet_lut_layer: RTL

Parametrised, pipelined LogicNet layer of `N_NEURONS` truth-table neurons, each mapping a `FAN_IN*IN_BITS`-bit address to an `OUT_BITS`-bit activation. It supersedes the per-neuron fixed ROM modules: tables are runtime-programmable through a config write port, and data moves through a 2-stage valid/ready pipeline with backpressure. It sits between layer-input routing (already sliced per neuron) and the next layer or the classifier output.

---
 rtl/logicnet_pkg.sv | 28 ++
 rtl/logicnet_lut_ram.sv | 25 ++
 rtl/logicnet_lut_layer.sv | 103 ++++++++++
 3 files changed

// File: rtl/logicnet_pkg.sv
// Shared parameters, width helpers and config record for the LogicNet LUT layer.
package logicnet_pkg;

    localparam int DEF_N_NEURONS = 4;
    localparam int DEF_FAN_IN    = 2;
    localparam int DEF_IN_BITS   = 2;
    localparam int DEF_OUT_BITS  = 2;
    localparam int DEF_CNT_W     = 16;

    function automatic int calc_aw(input int fan_in, input int in_bits);
        return fan_in * in_bits;
    endfunction

    // A single-neuron layer still needs a 1-bit select so out-of-range writes are expressible.
    function automatic int calc_sel_w(input int n_neurons);
        return (n_neurons > 1) ? $clog2(n_neurons) : 1;
    endfunction

    localparam int DEF_AW    = calc_aw(DEF_FAN_IN, DEF_IN_BITS);
    localparam int DEF_SEL_W = calc_sel_w(DEF_N_NEURONS);

    typedef struct packed {
        logic [DEF_SEL_W-1:0]    neuron;
        logic [DEF_AW-1:0]       addr;
        logic [DEF_OUT_BITS-1:0] data;
    } neuron_cfg_t;

endpackage

// File: rtl/logicnet_lut_ram.sv
// One neuron truth table: synchronous write, asynchronous read, no reset.
module logicnet_lut_ram #(
    parameter int AW       = 4,
    parameter int OUT_BITS = 2
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       wr_addr,
    input  logic [OUT_BITS-1:0] wr_data,
    input  logic [AW-1:0]       rd_addr,
    output logic [OUT_BITS-1:0] rd_data
);

    logic [OUT_BITS-1:0] mem_q [2**AW];

    // Contents survive reset; software owns initialisation.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/logicnet_lut_layer.sv
// Layer of runtime-programmable truth-table neurons behind a 2-stage valid/ready pipeline.
module logicnet_lut_layer
    import logicnet_pkg::*;
#(
    parameter  int N_NEURONS = DEF_N_NEURONS,
    parameter  int FAN_IN    = DEF_FAN_IN,
    parameter  int IN_BITS   = DEF_IN_BITS,
    parameter  int OUT_BITS  = DEF_OUT_BITS,
    parameter  int CNT_W     = DEF_CNT_W,
    localparam int AW        = calc_aw(FAN_IN, IN_BITS),
    localparam int SEL_W     = calc_sel_w(N_NEURONS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_NEURONS*AW-1:0]       in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_NEURONS*OUT_BITS-1:0] out_data,
    input  logic                          cfg_we,
    input  logic [SEL_W-1:0]              cfg_neuron,
    input  logic [AW-1:0]                 cfg_addr,
    input  logic [OUT_BITS-1:0]           cfg_data,
    output logic [CNT_W-1:0]              out_count
);

    logic                          s1_valid_q, s1_valid_d;
    logic [N_NEURONS*AW-1:0]       s1_addr_q, s1_addr_d;
    logic                          out_valid_q, out_valid_d;
    logic [N_NEURONS*OUT_BITS-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]              out_count_q, out_count_d;
    logic [N_NEURONS*OUT_BITS-1:0] lut_rd;
    logic                          s2_free, s1_adv, in_fire, out_fire;

    // Out-of-range neuron selects match no instance, so those writes fall away.
    for (genvar k = 0; k < N_NEURONS; k++) begin : g_neuron
        logic we;
        assign we = cfg_we && (cfg_neuron == SEL_W'(k));

        logicnet_lut_ram #(
            .AW       (AW),
            .OUT_BITS (OUT_BITS)
        ) u_ram (
            .clk     (clk),
            .we      (we),
            .wr_addr (cfg_addr),
            .wr_data (cfg_data),
            .rd_addr (s1_addr_q[k*AW +: AW]),
            .rd_data (lut_rd[k*OUT_BITS +: OUT_BITS])
        );
    end

    assign s2_free  = !out_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s2_free;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_addr_d   = s1_addr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q + CNT_W'(out_fire);

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_addr_d  = in_data;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        // Table read is sampled at the same edge a config write lands, so it sees the old entry.
        if (s1_adv) begin
            out_valid_d = 1'b1;
            out_data_d  = lut_rd;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_addr_q   <= s1_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

endmodule
